// File: rtl/ecp5pll_phase_ctrl.sv
// ecp5pll_phase_ctrl: sequences ECP5 PLL dynamic phase steps toward per-channel targets
// Optional ECP5PLL_PHASE_SHORTEST_EN: step backwards when that is the shorter way round.
module ecp5pll_phase_ctrl #(
  parameter int CHANNELS  = 4,
  parameter int STEP_W    = 10,
  parameter int STEPS0    = 8,
  parameter int STEPS1    = 8,
  parameter int STEPS2    = 8,
  parameter int STEPS3    = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int LOCK_WAIT = 1024
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_ch,
  input  logic [STEP_W-1:0] req_phase,
  output logic              done,
  output logic              err,
  output logic              busy,
  input  logic              locked,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              phaseloadreg
);
  localparam int DW = STEP_W + 1;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, FINISH, REJECT, WAIT_LOCK, REAPPLY} state_t;
  state_t r_state, w_next;
  logic r_lock_m, r_lock_s, r_seen, r_reapply, r_abort, r_dir;
  logic [2:0] r_ch;
  logic [DW-1:0] r_rem;
  logic [31:0] r_tmr;
  logic [STEP_W-1:0] r_cur [4];
  logic [STEP_W-1:0] r_tgt [4];
  logic [1:0] w_sel;
  logic [DW-1:0] w_steps, w_t, w_c, w_sum, w_d, w_cnt;
  logic [STEP_W-1:0] w_cn, w_smax, w_step_n;
  logic w_dir, w_bad, w_accept, w_tdone;
  always_comb begin
    w_sel = r_state == IDLE ? req_ch : r_ch[1:0];
    w_steps = w_sel == 2'd0 ? DW'(STEPS0) : w_sel == 2'd1 ? DW'(STEPS1) :
              w_sel == 2'd2 ? DW'(STEPS2) : DW'(STEPS3);
    w_smax = STEP_W'(w_steps - 1'b1);
    w_cn = r_cur[w_sel];
    w_t = r_state == IDLE ? {1'b0, req_phase} : {1'b0, r_tgt[w_sel]};
    w_c = {1'b0, w_cn};
    w_sum = w_t + w_steps - w_c;
    w_d = w_sum >= w_steps ? w_sum - w_steps : w_sum;
`ifdef ECP5PLL_PHASE_SHORTEST_EN
    w_dir = w_d > (w_steps >> 1);
    w_cnt = w_dir ? w_steps - w_d : w_d;
`else
    w_dir = 1'b0;
    w_cnt = w_d;
`endif
    w_step_n = r_dir ? (w_cn == '0 ? w_smax : w_cn - 1'b1) : (w_cn == w_smax ? '0 : w_cn + 1'b1);
    w_bad = {1'b0, req_ch} >= 3'(CHANNELS) || w_t >= w_steps;
    w_accept = r_state == IDLE && req_valid && r_lock_s;
    w_tdone = r_tmr == 32'(r_state == SETUP ? SETUP_CYC - 1 : r_state == PULSE ? PULSE_CYC - 1 :
                           r_state == GAP ? GAP_CYC - 1 : LOCK_WAIT - 1);
  end
  // An idle controller that has never seen lock (just out of reset) waits in IDLE, not WAIT_LOCK.
  always_comb begin
    w_next = r_state;
    if (!r_lock_s && r_state != WAIT_LOCK && (r_state != IDLE || r_seen)) w_next = WAIT_LOCK;
    else
      case (r_state)
        IDLE:      if (w_accept) w_next = w_bad ? REJECT : (w_d == '0 ? FINISH : SETUP);
        SETUP:     if (w_tdone) w_next = PULSE;
        PULSE:     if (w_tdone) w_next = GAP;
        GAP:       if (w_tdone) w_next = r_rem != '0 ? PULSE : r_reapply ? REAPPLY : FINISH;
        WAIT_LOCK: if (r_lock_s && w_tdone) w_next = REAPPLY;
        REAPPLY:   w_next = r_ch >= 3'(CHANNELS) ? IDLE : w_d != '0 ? SETUP : REAPPLY;
        default:   w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_lock_m <= 1'b0;
      r_lock_s <= 1'b0;
      r_seen <= 1'b0;
      r_reapply <= 1'b0;
      r_abort <= 1'b0;
      r_dir <= 1'b0;
      r_ch <= '0;
      r_rem <= '0;
      r_tmr <= '0;
      for (int n = 0; n < 4; n++) begin
        r_cur[n] <= '0;
        r_tgt[n] <= '0;
      end
    end else begin
      r_lock_m <= locked;
      r_lock_s <= r_lock_m;
      r_seen <= r_seen | r_lock_s;
      r_tmr <= (w_next != r_state || (r_state == WAIT_LOCK && !r_lock_s)) ? '0 : r_tmr + 1'b1;
      r_abort <= w_next == WAIT_LOCK && !r_reapply && (r_state == SETUP || r_state == PULSE || r_state == GAP);
      if (w_accept) r_ch <= {1'b0, req_ch};
      if (w_accept && !w_bad) r_tgt[req_ch] <= req_phase;
      if (w_next == SETUP) begin
        r_dir <= w_dir;
        r_rem <= w_cnt;
      end
      if (r_state == PULSE && w_next == GAP) begin
        r_cur[r_ch[1:0]] <= w_step_n;
        r_rem <= r_rem - 1'b1;
      end
      if (r_state == WAIT_LOCK)
        for (int n = 0; n < 4; n++) r_cur[n] <= '0;
      if (r_state == WAIT_LOCK && w_next == REAPPLY) begin
        r_ch <= '0;
        r_reapply <= 1'b1;
      end
      if ((r_state == REAPPLY || r_state == GAP) && w_next == REAPPLY) r_ch <= r_ch + 1'b1;
      if (w_next == IDLE) r_reapply <= 1'b0;
    end
  end
  assign req_ready = r_state == IDLE && r_lock_s;
  assign done = r_state == FINISH || r_state == REJECT || r_abort;
  assign err = r_state == REJECT || r_abort;
  assign busy = r_state != IDLE;
  assign phasesel = r_ch[1:0];
  assign phasedir = r_dir;
  assign phasestep = r_state == PULSE;
  assign phaseloadreg = 1'b0;
endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// tb_ecp5pll_phase_ctrl: directed checks of stepping, rejection, lock loss and reset
module tb_ecp5pll_phase_ctrl;
  logic clk_i = 1'b0, reset = 1'b1, req_valid = 1'b0, locked = 1'b0;
  logic [1:0] req_ch = '0;
  logic [9:0] req_phase = '0;
  logic req_ready, done, err, busy, phasedir, phasestep, phaseloadreg;
  logic [1:0] phasesel;
  int tests = 0, fails = 0;
`ifdef ECP5PLL_PHASE_SHORTEST_EN
  localparam logic SH = 1'b1;
`else
  localparam logic SH = 1'b0;
`endif
  always #5 clk_i = ~clk_i;
  ecp5pll_phase_ctrl #(.STEPS0(8), .STEPS1(16), .STEPS2(8), .STEPS3(16)) dut (
    .clk_i(clk_i), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_phase(req_phase), .done(done), .err(err), .busy(busy),
    .locked(locked), .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .phaseloadreg(phaseloadreg)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic req_chk(input string tag, input logic [1:0] ch, input logic [9:0] ph, input logic xdir,
                         input int xcyc, input int xerr, input int xnp);
    int c, dcyc, derr, np, bad, rdy;
    logic prev;
    @(negedge clk_i);
    rdy = int'(req_ready);
    req_valid = 1'b1; req_ch = ch; req_phase = ph;
    @(negedge clk_i);
    req_valid = 1'b0;
    dcyc = -1; derr = -1; np = 0; bad = 0; prev = 1'b0; c = 1;
    while (dcyc < 0 && c <= 300) begin
      if (phasestep && !prev) np++;
      if (phasestep && (phasedir !== xdir || phasesel !== ch)) bad++;
      prev = phasestep;
      if (done) begin
        dcyc = c;
        derr = int'(err);
      end else begin
        c++;
        @(negedge clk_i);
      end
    end
    chk({tag, "_ready"}, rdy, 1);
    chk({tag, "_done_cycle"}, dcyc, xcyc);
    chk({tag, "_err"}, derr, xerr);
    chk({tag, "_pulses"}, np, xnp);
    chk({tag, "_sel_dir_bad"}, bad, 0);
  endtask
  initial begin
    int c, n, ab, np, bad, dn;
    logic prev;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", req_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", phasesel, 0);
    chk("rst_dir", phasedir, 0);
    chk("rst_step", phasestep, 0);
    chk("rst_loadreg", phaseloadreg, 0);
    reset = 1'b0; locked = 1'b1;
    @(negedge clk_i);
    chk("sync_1cyc_ready", req_ready, 0);
    @(negedge clk_i);
    chk("sync_2cyc_ready", req_ready, 1);
    req_chk("ch0_fwd3", 2'd0, 10'd3, 1'b0, 27, 0, 3);
    req_chk("ch0_same", 2'd0, 10'd3, 1'b0, 1, 0, 0);
    req_chk("ch1_to1", 2'd1, 10'd1, 1'b0, 11, 0, 1);
    req_chk("ch1_to14", 2'd1, 10'd14, SH, SH ? 27 : 107, 0, SH ? 3 : 13);
    req_chk("ch2_reject", 2'd2, 10'd8, 1'b0, 1, 1, 0);
    req_chk("ch2_zero", 2'd2, 10'd0, 1'b0, 1, 0, 0);
    req_chk("ch0_tie", 2'd0, 10'd7, 1'b0, 35, 0, 4);
    req_chk("ch0_wrap", 2'd0, 10'd0, 1'b0, 11, 0, 1);
    req_chk("ch1_wrap0", 2'd1, 10'd0, 1'b0, 19, 0, 2);
    @(negedge clk_i);
    req_valid = 1'b1; req_ch = 2'd3; req_phase = 10'd5;
    @(negedge clk_i);
    req_valid = 1'b0;
    n = 0; prev = 1'b0; c = 0;
    while (n < 2 && c < 200) begin
      if (phasestep && !prev) n++;
      prev = phasestep;
      if (n < 2) begin
        c++;
        @(negedge clk_i);
      end
    end
    chk("lock_second_pulse", n, 2);
    locked = 1'b0;
    ab = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_i);
      if (done && err) ab++;
    end
    chk("lock_step_low", phasestep, 0);
    chk("lock_abort_done_err", ab, 1);
    @(negedge clk_i);
    chk("lock_busy", busy, 1);
    chk("lock_ready", req_ready, 0);
    chk("lock_done_once", done, 0);
    locked = 1'b1;
    np = 0; bad = 0; dn = 0; prev = 1'b0; c = 0;
    while (!req_ready && c < 1500) begin
      if (phasestep && !prev) np++;
      if (phasestep && (phasedir !== 1'b0 || phasesel !== 2'd3)) bad++;
      if (done) dn++;
      prev = phasestep;
      c++;
      @(negedge clk_i);
    end
    chk("reapply_ready", req_ready, 1);
    chk("reapply_pulses", np, 5);
    chk("reapply_sel_dir_bad", bad, 0);
    chk("reapply_no_done", dn, 0);
    req_chk("ch3_after_reapply", 2'd3, 10'd5, 1'b0, 1, 0, 0);
    @(negedge clk_i);
    req_valid = 1'b1; req_ch = 2'd3; req_phase = 10'd9;
    @(negedge clk_i);
    req_valid = 1'b0;
    c = 0;
    while (!phasestep && c < 50) begin
      c++;
      @(negedge clk_i);
    end
    chk("rstmid_pulse_seen", phasestep, 1);
    reset = 1'b1;
    @(negedge clk_i);
    chk("rstmid_step", phasestep, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    reset = 1'b0;
    c = 0;
    while (!req_ready && c < 20) begin
      c++;
      @(negedge clk_i);
    end
    chk("rstmid_ready", req_ready, 1);
    req_chk("ch3_after_reset", 2'd3, 10'd0, 1'b0, 1, 0, 0);
    req_chk("ch1_after_reset", 2'd1, 10'd1, 1'b0, 11, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
